// File: rtl/axis_burst_scheduler.sv
// Command-queued AXIS counter-pattern burst source: buffers (len, gap, tag) commands,
// streams each as a tlast-terminated packet, idles for the programmed gap, counts completions.
module axis_burst_scheduler #(
    parameter int unsigned CMD_DEPTH_LOG2 = 2,
    parameter int unsigned LEN_W          = 26,
    parameter int unsigned GAP_W          = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len_m1,
    input  logic [GAP_W-1:0]        cmd_gap,
    input  logic [3:0]              cmd_tag,
    input  logic                    enable,
    input  logic                    abort,
    output logic [31:0]             axis_tdata,
    output logic [3:0]              axis_tkeep,
    output logic                    axis_tlast,
    output logic                    axis_tvalid,
    input  logic                    axis_tready,
    output logic                    busy,
    output logic [CMD_DEPTH_LOG2:0] fifo_level,
    output logic [15:0]             done_count,
    output logic                    done_pulse
);
    localparam int unsigned DEPTH = 1 << CMD_DEPTH_LOG2;
    localparam int unsigned PTR_W = CMD_DEPTH_LOG2;
    localparam int unsigned LVL_W = CMD_DEPTH_LOG2 + 1;
    localparam int unsigned CMD_W = LEN_W + GAP_W + 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t             state;
    logic [CMD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEN_W-1:0]   head_len;
    logic [GAP_W-1:0]   head_gap;
    logic [3:0]         head_tag;
    logic [LEN_W-1:0]   len_m1;
    logic [LEN_W-1:0]   word_index;
    logic [GAP_W-1:0]   gap;
    logic [GAP_W-1:0]   gap_ctr;
    logic [3:0]         tag;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Ready and pop both depend on abort/rst so a flush cycle neither accepts nor launches.
    assign fifo_full  = (fifo_level == LVL_W'(DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign cmd_ready  = !fifo_full && !abort && !rst;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && enable && !fifo_empty && !abort && !rst;

    assign {head_len, head_gap, head_tag} = mem[rd_ptr];

    assign axis_tdata = {tag, 2'b00, 26'(word_index)};
    assign axis_tkeep = axis_tvalid ? 4'hf : 4'h0;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_len_m1, cmd_gap, cmd_tag};
        end
    end

    // Command FIFO pointers and occupancy; abort flushes everything queued.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Burst sequencer: tvalid/tlast are flops so they stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            axis_tvalid <= 1'b0;
            axis_tlast  <= 1'b0;
            done_pulse  <= 1'b0;
            done_count  <= '0;
            len_m1      <= '0;
            word_index  <= '0;
            gap         <= '0;
            gap_ctr     <= '0;
            tag         <= '0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        len_m1      <= head_len;
                        gap         <= head_gap;
                        tag         <= head_tag;
                        word_index  <= '0;
                        axis_tvalid <= 1'b1;
                        axis_tlast  <= (head_len == '0);
                        state       <= STREAM;
                    end
                end
                STREAM: begin
                    if (axis_tready) begin
                        if (axis_tlast) begin
                            axis_tvalid <= 1'b0;
                            axis_tlast  <= 1'b0;
                            done_pulse  <= 1'b1;
                            done_count  <= done_count + 16'd1;
                            if (gap == '0) begin
                                state <= IDLE;
                            end else begin
                                gap_ctr <= gap - GAP_W'(1);
                                state   <= GAP;
                            end
                        end else begin
                            word_index <= word_index + LEN_W'(1);
                            axis_tlast <= ((word_index + LEN_W'(1)) == len_m1);
                        end
                    end
                end
                GAP: begin
                    if (gap_ctr == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_ctr <= gap_ctr - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
